// File: rtl/fma_norm_seq.sv
`default_nettype none
// ============================================================================
// Module   : fma_norm_seq
// Purpose  : Iterative normalizer for the FMA compound-adder sum. Left-shifts
//            the magnitude until the top bit is set, using a coarse STEP-bit
//            shift loop followed by a single fine leading-zero shift within
//            the top STEP-bit window.
// Ports    : clk, reset       - clock, synchronous active-high reset
//            in_valid/in_ready - operand handshake (ready only when idle)
//            sum, sign_in      - adder magnitude and result sign
//            out_valid/out_ready - result handshake (valid only when done)
//            norm, shamt       - normalized mantissa, total left shift
//            zero, sign_out    - all-zero input flag, carried sign
// Revision : 1.0 - initial release
// ============================================================================
module fma_norm_seq #(
    parameter int WIDTH = 158,
    parameter int STEP  = 32,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum,
    input  logic             sign_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] norm,
    output logic [CNTW-1:0]  shamt,
    output logic             zero,
    output logic             sign_out
);

    localparam int              c_LZW      = $clog2(STEP);
    localparam logic [CNTW-1:0] c_STEP_CNT = CNTW'(STEP);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COARSE = 2'd1,
        S_FINE   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CNTW-1:0]  r_cnt;
    logic             r_zero;
    logic             r_sign;

    logic [STEP-1:0]  w_top;
    logic [c_LZW-1:0] w_lz;

    // Leading-zero count of the top window. Only evaluated in FINE, where
    // the coarse loop has guaranteed the window is nonzero, so the count
    // always fits in c_LZW bits.
    function automatic logic [c_LZW-1:0] lzc(input logic [STEP-1:0] v);
        logic [c_LZW-1:0] n;
        logic             found;
        n     = '0;
        found = 1'b0;
        for (int i = STEP - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + 1'b1;
                end
            end
        end
        return n;
    endfunction

    assign w_top = r_acc[WIDTH-1 -: STEP];
    assign w_lz  = lzc(w_top);

    // Handshake flags depend on the state register only.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);

    assign norm     = r_acc;
    assign shamt    = r_cnt;
    assign zero     = r_zero;
    assign sign_out = r_sign;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_zero  <= 1'b0;
            r_sign  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_acc  <= sum;
                        r_cnt  <= '0;
                        r_sign <= sign_in;
                        if (sum == '0) begin
                            r_zero  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_zero  <= 1'b0;
                            r_state <= S_COARSE;
                        end
                    end
                end
                S_COARSE: begin
                    // Whole empty windows are skipped STEP bits at a time;
                    // bits leaving the top are known zero.
                    if (w_top == '0) begin
                        r_acc <= r_acc << STEP;
                        r_cnt <= r_cnt + c_STEP_CNT;
                    end else begin
                        r_state <= S_FINE;
                    end
                end
                S_FINE: begin
                    r_acc   <= r_acc << w_lz;
                    r_cnt   <= r_cnt + CNTW'(w_lz);
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
